// File: rtl/ripple_count_sampler_pkg.sv
// Shared types and default widths for the ripple-count sampler.
// The FSM walks IDLE (baseline) -> SETTLE (watch) -> UPDATE (one-cycle pulse).
package ripple_count_sampler_pkg;

    localparam int IN_W_DEF  = 3;
    localparam int ACC_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        UPDATE = 2'd2
    } state_e;

endpackage

// File: rtl/ripple_count_sampler_bit_sync.sv
// Per-bit multi-flop synchronizer for a bus whose bits change independently.
// Every bit gets its own SYNC_STAGES-deep chain; no cross-bit coherence is implied.
module ripple_count_sampler_bit_sync
    import ripple_count_sampler_pkg::*;
#(
    parameter int WIDTH       = IN_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_d;

    // shift the raw input one stage per clock
    always_comb begin
        chain_d[0] = d_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    // synchronizer flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_out = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple count, filters transients, and accumulates
// modulo deltas between accepted values into a wide total with sticky flags.
module ripple_count_sampler
    import ripple_count_sampler_pkg::*;
#(
    parameter int IN_W          = IN_W_DEF,
    parameter int ACC_W         = ACC_W_DEF,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  count_in,
    input  logic             clr,
    input  logic [ACC_W-1:0] threshold,
    output logic [ACC_W-1:0] total,
    output logic [IN_W-1:0]  delta,
    output logic             upd_valid,
    output logic             thr_hit,
    output logic             ovf
);

    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    logic [IN_W-1:0]  s_s;
    logic [IN_W-1:0]  prev_q, prev_d;
    logic [RUN_W-1:0] run_q, run_d;
    state_e           state_q, state_d;
    logic [IN_W-1:0]  acc_val_q, acc_val_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic [IN_W-1:0]  delta_q, delta_d;
    logic             upd_valid_q, upd_valid_d;
    logic             thr_hit_q, thr_hit_d;
    logic             ovf_q, ovf_d;

    logic             stable_s;
    logic             accept_s;
    logic             thr_reach_s;
    logic [IN_W-1:0]  diff_s;
    logic [ACC_W:0]   sum_s;

    ripple_count_sampler_bit_sync #(
        .WIDTH       (IN_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (count_in),
        .q_out (s_s)
    );

    // A saturated run is only trusted while the current sample still matches;
    // otherwise the first new value would be accepted before its run restarts.
    assign stable_s    = (run_q == RUN_MAX) && (s_s == prev_q);
    assign accept_s    = (state_q == SETTLE) && stable_s && (s_s != acc_val_q);
    assign diff_s      = s_s - acc_val_q;
    assign sum_s       = {1'b0, total_q} + {{(ACC_W + 1 - IN_W){1'b0}}, diff_s};
    assign thr_reach_s = (threshold != '0) && (total_q >= threshold);

    // stability filter: count consecutive equal synchronized samples
    always_comb begin
        prev_d = s_s;
        if (accept_s || (s_s != prev_q)) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
        end else begin
            run_d = run_q;
        end
    end

    // FSM next state, accumulator and flag update; clr overrides accumulation only
    always_comb begin
        state_d     = state_q;
        acc_val_d   = acc_val_q;
        total_d     = total_q;
        delta_d     = delta_q;
        upd_valid_d = 1'b0;
        ovf_d       = ovf_q;
        thr_hit_d   = thr_hit_q;
        case (state_q)
            IDLE: begin
                if (stable_s) begin
                    acc_val_d = s_s;
                    state_d   = SETTLE;
                end else begin
                    state_d   = IDLE;
                end
            end
            SETTLE: begin
                if (accept_s) begin
                    acc_val_d   = s_s;
                    state_d     = UPDATE;
                    total_d     = sum_s[ACC_W-1:0];
                    delta_d     = diff_s;
                    upd_valid_d = 1'b1;
                    ovf_d       = ovf_q | sum_s[ACC_W];
                end else begin
                    state_d     = SETTLE;
                end
            end
            UPDATE: begin
                state_d = SETTLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clr) begin
            total_d     = '0;
            delta_d     = '0;
            ovf_d       = 1'b0;
            thr_hit_d   = 1'b0;
            upd_valid_d = 1'b0;
        end else begin
            thr_hit_d   = thr_hit_q | thr_reach_s;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q      <= '0;
            run_q       <= '0;
            state_q     <= IDLE;
            acc_val_q   <= '0;
            total_q     <= '0;
            delta_q     <= '0;
            upd_valid_q <= 1'b0;
            thr_hit_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            run_q       <= run_d;
            state_q     <= state_d;
            acc_val_q   <= acc_val_d;
            total_q     <= total_d;
            delta_q     <= delta_d;
            upd_valid_q <= upd_valid_d;
            thr_hit_q   <= thr_hit_d;
            ovf_q       <= ovf_d;
        end
    end

    assign total     = total_q;
    assign delta     = delta_q;
    assign upd_valid = upd_valid_q;
    assign thr_hit   = thr_hit_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ripple_count_sampler.sv
// Bench for ripple_count_sampler (ACC_W=4 so wrap/overflow is reachable):
// directed scenarios with literal expectations plus a randomized run against a window-based model.
module tb_ripple_count_sampler;

    localparam int IN_W  = 3;
    localparam int ACC_W = 4;
    localparam int SYNC  = 2;
    localparam int STAB  = 2;
    localparam int ACC_M = 1 << ACC_W;
    localparam int IN_M  = 1 << IN_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic [IN_W-1:0]  count_in = '0;
    logic [ACC_W-1:0] threshold = '0;
    logic [ACC_W-1:0] total;
    logic [IN_W-1:0]  delta;
    logic             upd_valid;
    logic             thr_hit;
    logic             ovf;

    ripple_count_sampler #(
        .IN_W          (IN_W),
        .ACC_W         (ACC_W),
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STAB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .count_in  (count_in),
        .clr       (clr),
        .threshold (threshold),
        .total     (total),
        .delta     (delta),
        .upd_valid (upd_valid),
        .thr_hit   (thr_hit),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int upd_pulses = 0;

    // model: raw samples delayed by the sync depth, a window of the last
    // STAB+2 synchronized values, and edges elapsed since reset/acceptance
    int raw_q[$];
    int s_win[$];
    int quiet;
    int m_mode;
    int m_base, m_total, m_delta, m_upd, m_thr, m_ovf;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        raw_q = {};
        s_win = {};
        for (int i = 0; i < SYNC; i++) raw_q.push_back(0);
        for (int i = 0; i < STAB + 2; i++) s_win.push_back(0);
        quiet = 0;
        m_mode = 0;
        m_base = 0; m_total = 0; m_delta = 0; m_upd = 0; m_thr = 0; m_ovf = 0;
    endtask

    task automatic model_step();
        int s, d, sum, thr_new;
        bit steady, accept;
        if (!rst) begin
            model_reset();
        end else begin
            s = raw_q.pop_front();
            raw_q.push_back(int'(count_in));
            void'(s_win.pop_front());
            s_win.push_back(s);
            steady = (quiet >= STAB);
            for (int i = 1; i < STAB + 2; i++) begin
                if (s_win[i] != s_win[0]) steady = 1'b0;
            end
            thr_new = (m_thr != 0 || (threshold != '0 && m_total >= int'(threshold))) ? 1 : 0;
            accept = 1'b0;
            d = 0;
            m_upd = 0;
            if (m_mode == 0) begin
                if (steady) begin
                    m_base = s;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (steady && s != m_base) begin
                    d = (s - m_base + IN_M) % IN_M;
                    m_base = s;
                    m_mode = 2;
                    accept = 1'b1;
                end
            end else begin
                m_mode = 1;
            end
            if (clr) begin
                m_total = 0; m_delta = 0; m_ovf = 0; thr_new = 0;
            end else if (accept) begin
                sum = m_total + d;
                if (sum >= ACC_M) m_ovf = 1;
                m_total = sum % ACC_M;
                m_delta = d;
                m_upd = 1;
            end
            m_thr = thr_new;
            quiet = accept ? 0 : ((quiet < 100) ? quiet + 1 : quiet);
        end
    endtask

    // per-cycle compare of every output against the model
    always @(posedge clk) begin
        model_step();
        #1;
        check("total", int'(total), m_total);
        check("delta", int'(delta), m_delta);
        check("upd_valid", int'(upd_valid), m_upd);
        check("thr_hit", int'(thr_hit), m_thr);
        check("ovf", int'(ovf), m_ovf);
        if (upd_valid) upd_pulses++;
    end

    task automatic apply_and_wait(input int v, output int lat);
        lat = 0;
        @(negedge clk);
        count_in = IN_W'(v);
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(posedge clk);
            #2;
            if (upd_valid) lat = i;
        end
    endtask

    task automatic step(input int v, input string name, input int exp_delta, input int exp_total);
        int lat;
        apply_and_wait(v, lat);
        check({name, "_latency"}, lat, 6);
        check({name, "_delta"}, int'(delta), exp_delta);
        check({name, "_total"}, int'(total), exp_total);
        check({name, "_model_total"}, m_total, exp_total);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int lat, p0, hold;
        model_reset();
        count_in = 3'd5;
        repeat (3) @(negedge clk);
        check("reset_total", int'(total), 0);
        check("reset_upd", int'(upd_valid), 0);
        rst = 1'b1;
        repeat (12) @(negedge clk);
        check("baseline_no_upd", upd_pulses, 0);
        check("baseline_total", int'(total), 0);

        step(6, "single", 1, 1);
        step(7, "step7", 1, 2);
        step(1, "wrap", 2, 4);

        p0 = upd_pulses;
        @(negedge clk) count_in = 3'd3;
        @(negedge clk);
        @(negedge clk) count_in = 3'd1;
        repeat (12) @(negedge clk);
        check("glitch_pulses", upd_pulses, p0);
        check("glitch_total", int'(total), 4);

        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        check("clr_total", int'(total), 0);
        threshold = 4'd5;
        step(4, "thr_a", 3, 3);
        check("thr_a_flag", int'(thr_hit), 0);
        apply_and_wait(7, lat);
        check("thr_b_latency", lat, 6);
        check("thr_b_total", int'(total), 6);
        check("thr_b_flag_early", int'(thr_hit), 0);
        @(posedge clk);
        #2;
        check("thr_b_flag", int'(thr_hit), 1);
        repeat (6) @(negedge clk);
        step(6, "ovf_a", 7, 13);
        check("ovf_a_flag", int'(ovf), 0);
        step(5, "ovf_b", 7, 4);
        check("ovf_b_flag", int'(ovf), 1);
        check("thr_sticky", int'(thr_hit), 1);

        p0 = upd_pulses;
        @(negedge clk) count_in = 3'd0;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        check("coll_upd", int'(upd_valid), 0);
        check("coll_total", int'(total), 0);
        check("coll_ovf", int'(ovf), 0);
        check("coll_pulses", upd_pulses, p0);
        repeat (6) @(negedge clk);
        step(2, "after_coll", 2, 2);

        apply_and_wait(4, lat);
        check("pre_rst_upd", int'(upd_valid), 1);
        #1 rst = 1'b0;
        #1;
        check("rst_upd", int'(upd_valid), 0);
        check("rst_total", int'(total), 0);
        check("rst_delta", int'(delta), 0);
        check("rst_ovf", int'(ovf), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        p0 = upd_pulses;
        repeat (14) @(negedge clk);
        check("rebase_pulses", upd_pulses, p0);
        step(5, "after_rst", 1, 1);

        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                count_in = IN_W'($urandom_range(0, IN_M - 1));
                hold = $urandom_range(1, 9);
            end
            hold--;
            clr = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 63) == 0) threshold = ACC_W'($urandom_range(0, ACC_M - 1));
        end
        @(negedge clk);
        clr = 1'b0;
        rst = 1'b1;
        repeat (12) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
